// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data wins over fetch; a stuck RAM is aborted after TIMEOUT wait cycles.
module mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] imemload,
    output logic [31:0] dmemload,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_ready,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [31:0]   addr_q;
    logic [31:0]   store_q;
    logic          wr_q;
    logic [CW-1:0] cnt;

    logic dreq, ireq;
    logic grant_i, grant_d;
    logic done, abort;

    // A requester still seeing its own hit is presenting a stale request.
    assign dreq = (dmemREN | dmemWEN) & ~dhit;
    assign ireq = imemREN & ~ihit;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        grant_i = 1'b0;
        grant_d = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE: begin
                if (dreq) begin
                    state_n = DACC;
                    grant_d = 1'b1;
                end else if (ireq) begin
                    state_n = IACC;
                    grant_i = 1'b1;
                end
            end
            IACC, DACC: begin
                if (ram_ready) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else if (cnt == CW'(TIMEOUT)) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
            cnt      <= '0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            imemload <= '0;
            dmemload <= '0;
            err      <= 1'b0;
        end else begin
            ihit <= done && (state == IACC);
            dhit <= done && (state == DACC);
            if (grant_d) begin
                addr_q  <= dmemaddr;
                store_q <= dmemstore;
                wr_q    <= dmemWEN;
                cnt     <= '0;
            end else if (grant_i) begin
                addr_q  <= imemaddr;
                store_q <= '0;
                wr_q    <= 1'b0;
                cnt     <= '0;
            end else if (state != IDLE && !done && !abort) begin
                cnt <= cnt + 1'b1;
            end
            if (done && state == IACC) imemload <= ram_load;
            if (done && state == DACC && !wr_q) dmemload <= ram_load;
            if (abort) err <= 1'b1;
        end
    end

    assign ram_ren   = (state == IACC) || (state == DACC && !wr_q);
    assign ram_wen   = (state == DACC) && wr_q;
    assign ram_addr  = (state == IDLE) ? '0 : addr_q;
    assign ram_store = (state == IDLE) ? '0 : store_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, priority, write, timeout, reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        nRST;
    logic        imemREN, dmemREN, dmemWEN;
    logic [31:0] imemaddr, dmemaddr, dmemstore;
    logic        ihit, dhit;
    logic [31:0] imemload, dmemload;
    logic        ram_ren, ram_wen;
    logic [31:0] ram_addr, ram_store, ram_load;
    logic        ram_ready, err;

    int n_cmp = 0;
    int n_bad = 0;
    int n;

    mem_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .nRST(nRST),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .ihit(ihit), .dhit(dhit),
        .imemload(imemload), .dmemload(dmemload),
        .ram_ren(ram_ren), .ram_wen(ram_wen),
        .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_load(ram_load), .ram_ready(ram_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        imemREN = 0; dmemREN = 0; dmemWEN = 0;
        imemaddr = 0; dmemaddr = 0; dmemstore = 0;
        ram_load = 0; ram_ready = 0;
        #3;
        chk("rst_ren", ram_ren, 0);
        chk("rst_wen", ram_wen, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_hits", {ihit, dhit}, 0);
        chk("rst_iload", imemload, 0);
        chk("rst_err", err, 0);
        tick();
        nRST = 1'b1;
        tick();

        // fetch, minimum latency
        imemREN = 1; imemaddr = 32'h40;
        tick();
        chk("if_ren", ram_ren, 1);
        chk("if_addr", ram_addr, 32'h40);
        chk("if_wen", ram_wen, 0);
        ram_ready = 1; ram_load = 32'h8C010004;
        tick();
        chk("if_ihit", ihit, 1);
        chk("if_dhit", dhit, 0);
        chk("if_load", imemload, 32'h8C010004);
        chk("if_idle", ram_ren, 0);
        ram_ready = 0;
        tick();
        chk("if_stale_ren", ram_ren, 0);
        chk("if_hit_pulse", ihit, 0);
        imemREN = 0;
        tick();

        // data priority, then stale data request yields to fetch
        imemREN = 1; imemaddr = 32'h44;
        dmemREN = 1; dmemaddr = 32'h100;
        tick();
        chk("pr_ren", ram_ren, 1);
        chk("pr_addr", ram_addr, 32'h100);
        dmemaddr = 32'h999;
        ram_ready = 1; ram_load = 32'h11112222;
        tick();
        chk("pr_dhit", dhit, 1);
        chk("pr_ihit", ihit, 0);
        chk("pr_dload", dmemload, 32'h11112222);
        ram_ready = 0;
        tick();
        chk("st_ren", ram_ren, 1);
        chk("st_addr", ram_addr, 32'h44);
        chk("st_nodhit", dhit, 0);
        dmemREN = 0;
        ram_ready = 1; ram_load = 32'h33334444;
        tick();
        chk("st_ihit", ihit, 1);
        chk("st_iload", imemload, 32'h33334444);
        imemREN = 0; ram_ready = 0;
        tick();

        // write (both strobes high counts as write)
        dmemWEN = 1; dmemREN = 1;
        dmemaddr = 32'h200; dmemstore = 32'hDEADBEEF;
        tick();
        chk("wr_wen", ram_wen, 1);
        chk("wr_ren", ram_ren, 0);
        chk("wr_addr", ram_addr, 32'h200);
        chk("wr_store", ram_store, 32'hDEADBEEF);
        ram_ready = 1; ram_load = 32'h55555555;
        tick();
        chk("wr_dhit", dhit, 1);
        chk("wr_dload", dmemload, 32'h11112222);
        dmemWEN = 0; dmemREN = 0; ram_ready = 0;
        tick();

        // ready while idle is ignored
        ram_ready = 1;
        tick();
        chk("idle_hits", {ihit, dhit}, 0);
        chk("idle_ren", ram_ren, 0);
        ram_ready = 0;
        tick();

        // ready on the last allowed cycle still completes
        imemREN = 1; imemaddr = 32'h7C;
        tick();
        imemREN = 0;
        repeat (15) tick();
        chk("edge_ren", ram_ren, 1);
        ram_ready = 1; ram_load = 32'hABCD0123;
        tick();
        chk("edge_ihit", ihit, 1);
        chk("edge_err", err, 0);
        ram_ready = 0;
        tick();

        // timeout
        imemREN = 1; imemaddr = 32'h80;
        tick();
        imemREN = 0;
        n = 0;
        while (ram_ren && n < 40) begin
            n++;
            tick();
        end
        chk("to_cycles", n, 16);
        chk("to_nohit", {ihit, dhit}, 0);
        chk("to_err", err, 1);
        tick();
        dmemREN = 1; dmemaddr = 32'h10;
        tick();
        dmemREN = 0;
        ram_ready = 1; ram_load = 32'h77;
        tick();
        chk("to_after_dhit", dhit, 1);
        chk("to_err_sticky", err, 1);
        ram_ready = 0;
        tick();

        // reset in the middle of a data access
        dmemREN = 1; dmemaddr = 32'h300;
        imemREN = 1; imemaddr = 32'h48;
        tick();
        chk("rm_ren", ram_ren, 1);
        chk("rm_addr", ram_addr, 32'h300);
        #1 nRST = 1'b0;
        #1;
        chk("rm_ren0", ram_ren, 0);
        chk("rm_addr0", ram_addr, 0);
        chk("rm_err0", err, 0);
        chk("rm_dload0", dmemload, 0);
        dmemREN = 0;
        #1 nRST = 1'b1;
        tick();
        chk("rm_grant", ram_ren, 1);
        chk("rm_gaddr", ram_addr, 32'h48);
        ram_ready = 1; ram_load = 32'h99;
        tick();
        chk("rm_ihit", ihit, 1);
        chk("rm_dhit", dhit, 0);
        chk("rm_iload", imemload, 32'h99);
        imemREN = 0; ram_ready = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
